// File: rtl/ibex_csr_rmw_pkg.sv
// Shared types and the read-modify-write value function
// for the CSR access initiator.
package ibex_csr_rmw_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SET   = 2'd2,
    OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_VERIFY,
    S_RESP
  } rmw_state_e;

  // Widest CSR the helper handles; callers zero-extend.
  localparam int unsigned MaxW = 64;

  function automatic logic [MaxW-1:0] rmw_compute(
    input csr_op_e         op,
    input logic [MaxW-1:0] old,
    input logic [MaxW-1:0] wdata
  );
    logic [MaxW-1:0] res;
    case (op)
      OP_WRITE: res = wdata;
      OP_SET:   res = old | wdata;
      OP_CLEAR: res = old & ~wdata;
      default:  res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ibex_csr_rmw_alu.sv
// New-value computation and write-needed flag for one
// CSR read-modify-write access.
module ibex_csr_rmw_alu
  import ibex_csr_rmw_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  csr_op_e          op,
  input  logic [Width-1:0] old,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] nxt,
  output logic             wr_need
);

  logic [MaxW-1:0] old_x;
  logic [MaxW-1:0] wdata_x;
  logic [MaxW-1:0] res;
  logic            unused_res;

  always_comb begin
    old_x = '0;
    wdata_x = '0;
    old_x[Width-1:0] = old;
    wdata_x[Width-1:0] = wdata;
    res = rmw_compute(op, old_x, wdata_x);
    nxt = res[Width-1:0];
  end

  assign unused_res = ^res;

  // A zero mask on SET/CLEAR cannot change the CSR.
  assign wr_need = (op == OP_WRITE) ||
                   (((op == OP_SET) || (op == OP_CLEAR)) &&
                    (|wdata));

endmodule

// File: rtl/ibex_csr_rmw_ctrl.sv
// CSR access initiator: read, modify, write, read back,
// then return the old value and an error flag.
module ibex_csr_rmw_ctrl
  import ibex_csr_rmw_pkg::*;
#(
  parameter  int unsigned Width  = 32,
  parameter  int unsigned NumCsr = 4,
  localparam int unsigned AddrW  = $clog2(NumCsr)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrW-1:0]        req_addr_i,
  input  logic [1:0]              req_op_i,
  input  logic [Width-1:0]        req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [Width-1:0]        rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [NumCsr-1:0]       csr_wr_en_o,
  output logic [Width-1:0]        csr_wr_data_o,
  input  logic [NumCsr*Width-1:0] csr_rd_data_i,
  input  logic [NumCsr-1:0]       csr_rd_error_i,
  output logic                    alert_o
);

  rmw_state_e        state;
  logic [AddrW-1:0]  addr_q;
  csr_op_e           op_q;
  logic [Width-1:0]  wdata_q;
  logic [Width-1:0]  new_q;
  logic [NumCsr-1:0] wr_en_q;

  logic [Width-1:0]  rd_sel;
  logic              rd_err;
  logic              in_range;
  logic [Width-1:0]  alu_nxt;
  logic              wr_need;

  always_comb begin
    rd_sel = '0;
    rd_err = 1'b0;
    in_range = 1'b0;
    for (int i = 0; i < NumCsr; i++) begin
      if (addr_q == AddrW'(i)) begin
        rd_sel = csr_rd_data_i[i*Width +: Width];
        rd_err = csr_rd_error_i[i];
        in_range = 1'b1;
      end
    end
  end

  ibex_csr_rmw_alu #(
    .Width(Width)
  ) u_alu (
    .op     (op_q),
    .old    (rd_sel),
    .wdata  (wdata_q),
    .nxt    (alu_nxt),
    .wr_need(wr_need)
  );

  // Reset wins even inside the write cycle.
  assign csr_wr_en_o = wr_en_q & ~{NumCsr{rst_i}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      wr_en_q       <= '0;
      csr_wr_data_o <= '0;
      alert_o       <= 1'b0;
      addr_q        <= '0;
      op_q          <= OP_READ;
      wdata_q       <= '0;
      new_q         <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i;
            op_q        <= csr_op_e'(req_op_i);
            wdata_q     <= req_wdata_i;
            req_ready_o <= 1'b0;
            state       <= S_READ;
          end
        end
        S_READ: begin
          rsp_rdata_o <= rd_sel;
          new_q       <= alu_nxt;
          rsp_err_o   <= !in_range || rd_err;
          if (in_range && rd_err) begin
            alert_o <= 1'b1;
          end
          if (in_range && !rd_err && wr_need) begin
            wr_en_q       <= NumCsr'(1) << addr_q;
            csr_wr_data_o <= alu_nxt;
            state         <= S_WRITE;
          end else begin
            rsp_valid_o <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_WRITE: begin
          wr_en_q       <= '0;
          csr_wr_data_o <= '0;
          state         <= S_VERIFY;
        end
        S_VERIFY: begin
          if ((rd_sel != new_q) || rd_err) begin
            rsp_err_o <= 1'b1;
            alert_o   <= 1'b1;
          end
          rsp_valid_o <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_csr_rmw_ctrl.sv
// Bench for ibex_csr_rmw_ctrl with a modelled CSR bank
// and a response scoreboard.
module tb_ibex_csr_rmw_ctrl;
  import ibex_csr_rmw_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_addr = '0;
  logic [1:0]  req_op = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [127:0] rd_flat;
  logic [3:0]  rderr = '0;
  logic        alert;

  logic        v3 = 1'b0;
  logic        rdy3;
  logic [1:0]  a3 = '0;
  logic [1:0]  op3 = '0;
  logic [31:0] wd3 = '0;
  logic        rv3;
  logic        rr3 = 1'b0;
  logic [31:0] rd3;
  logic        re3;
  logic [2:0]  en3;
  logic [31:0] wdat3;
  logic [95:0] rdflat3 = {32'h3333_3333, 32'h2222_2222,
                          32'h1111_1111};
  logic [2:0]  rerr3 = '0;
  logic        al3;

  logic [31:0] bank [4];
  logic        load_en = 1'b0;
  logic [1:0]  load_idx = '0;
  logic [31:0] load_val = '0;
  logic        drop1 = 1'b0;

  always #5 clk = ~clk;

  ibex_csr_rmw_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_op_i      (req_op),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .csr_wr_en_o   (wr_en),
    .csr_wr_data_o (wr_data),
    .csr_rd_data_i (rd_flat),
    .csr_rd_error_i(rderr),
    .alert_o       (alert)
  );

  ibex_csr_rmw_ctrl #(.NumCsr(3)) dut3 (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (v3),
    .req_ready_o   (rdy3),
    .req_addr_i    (a3),
    .req_op_i      (op3),
    .req_wdata_i   (wd3),
    .rsp_valid_o   (rv3),
    .rsp_ready_i   (rr3),
    .rsp_rdata_o   (rd3),
    .rsp_err_o     (re3),
    .csr_wr_en_o   (en3),
    .csr_wr_data_o (wdat3),
    .csr_rd_data_i (rdflat3),
    .csr_rd_error_i(rerr3),
    .alert_o       (al3)
  );

  // CSR bank model; drop1 makes CSR1 ignore writes.
  always @(posedge clk) begin
    if (load_en) begin
      bank[load_idx] <= load_val;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i] && !(drop1 && i == 1)) begin
          bank[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_flat = '0;
    for (int i = 0; i < 4; i++) begin
      rd_flat[i*32 +: 32] = bank[i];
    end
  end

  task automatic preload(input logic [1:0] idx,
                         input logic [31:0] v);
    @(negedge clk);
    load_en = 1'b1;
    load_idx = idx;
    load_val = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] a,
                        input logic [1:0] op,
                        input logic [31:0] wd,
                        input logic [3:0] exp_en,
                        input logic [31:0] exp_wd,
                        input int exp_lat,
                        input int hold,
                        input string nm);
    int w;
    int lat;
    int en_cyc;
    int en_extra;
    logic [3:0] en_seen;
    logic [31:0] dat_seen;
    exp_t e;
    w = 0;
    lat = -1;
    en_cyc = -1;
    en_extra = 0;
    en_seen = '0;
    dat_seen = '0;
    @(negedge clk);
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (req_ready !== 1'b1)
      $display("FAIL %s req_ready: got %b want 1",
               nm, req_ready);
    else passes++;
    req_valid = 1'b1;
    req_addr = a;
    req_op = op;
    req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (wr_en !== 4'b0) begin
        if (en_cyc < 0) begin
          en_cyc = c;
          en_seen = wr_en;
          dat_seen = wr_data;
        end else begin
          en_extra++;
        end
      end
      if (rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != exp_lat)
      $display("FAIL %s latency: got %0d want %0d",
               nm, lat, exp_lat);
    else passes++;
    checks++;
    if (en_seen !== exp_en || en_extra != 0)
      $display("FAIL %s wr_en: got %b x%0d want %b",
               nm, en_seen, en_extra + 1, exp_en);
    else passes++;
    if (exp_en != 4'b0) begin
      checks++;
      if (en_cyc != 2 || dat_seen !== exp_wd)
        $display("FAIL %s wr: got c%0d %h want c2 %h",
                 nm, en_cyc, dat_seen, exp_wd);
      else passes++;
    end
    e = sb.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err)
      $display("FAIL %s rsp: got %h/%b want %h/%b",
               nm, rsp_rdata, rsp_err, e.rdata, e.err);
    else passes++;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata ||
          rsp_err !== e.err || req_ready !== 1'b0)
        $display("FAIL %s hold%0d: got %b%h%b%b want 1%h%b0",
                 nm, h, rsp_valid, rsp_rdata, rsp_err,
                 req_ready, e.rdata, e.err);
      else passes++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL %s idle: got rdy%b v%b want rdy1 v0",
               nm, req_ready, rsp_valid);
    else passes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL reset rsp: got %b%b%h%b want 1000",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    else passes++;
    checks++;
    if (wr_en !== 4'b0 || wr_data !== 32'h0 ||
        alert !== 1'b0)
      $display("FAIL reset csr: got %b %h %b want 0 0 0",
               wr_en, wr_data, alert);
    else passes++;
  endtask

  task automatic test_write();
    preload(2'd1, 32'h0);
    sb.push_back('{32'h0, 1'b0});
    do_req(2'd1, OP_WRITE, 32'hDEAD_BEEF, 4'b0010,
           32'hDEAD_BEEF, 4, 0, "write");
    checks++;
    if (bank[1] !== 32'hDEAD_BEEF)
      $display("FAIL write bank: got %h want deadbeef",
               bank[1]);
    else passes++;
  endtask

  task automatic test_set();
    preload(2'd2, 32'h0000_000F);
    sb.push_back('{32'h0000_000F, 1'b0});
    do_req(2'd2, OP_SET, 32'h0000_00F0, 4'b0100,
           32'h0000_00FF, 4, 0, "set");
    sb.push_back('{32'h0000_00FF, 1'b0});
    do_req(2'd2, OP_SET, 32'h0, 4'b0, 32'h0, 2, 0,
           "set_zero");
  endtask

  task automatic test_clear_stall();
    preload(2'd0, 32'h1234_5678);
    sb.push_back('{32'h1234_5678, 1'b0});
    do_req(2'd0, OP_CLEAR, 32'hFFFF_0000, 4'b0001,
           32'h0000_5678, 4, 5, "clear");
  endtask

  task automatic test_rd_error();
    preload(2'd3, 32'hA5A5_0000);
    rderr = 4'b1000;
    sb.push_back('{32'hA5A5_0000, 1'b1});
    do_req(2'd3, OP_WRITE, 32'h0BAD_F00D, 4'b0, 32'h0,
           2, 0, "rd_error");
    rderr = 4'b0;
    checks++;
    if (alert !== 1'b1)
      $display("FAIL rd_error alert: got %b want 1", alert);
    else passes++;
    sb.push_back('{32'h0000_5678, 1'b0});
    do_req(2'd0, OP_READ, 32'h0, 4'b0, 32'h0, 2, 0,
           "clean0");
    sb.push_back('{32'h0000_00FF, 1'b0});
    do_req(2'd2, OP_READ, 32'h0, 4'b0, 32'h0, 2, 0,
           "clean2");
    checks++;
    if (alert !== 1'b1)
      $display("FAIL alert sticky: got %b want 1", alert);
    else passes++;
  endtask

  task automatic test_verify_mismatch();
    apply_reset();
    checks++;
    if (alert !== 1'b0)
      $display("FAIL alert cleared: got %b want 0", alert);
    else passes++;
    drop1 = 1'b1;
    sb.push_back('{32'hDEAD_BEEF, 1'b1});
    do_req(2'd1, OP_WRITE, 32'h5555_AAAA, 4'b0010,
           32'h5555_AAAA, 4, 0, "verify");
    drop1 = 1'b0;
    checks++;
    if (alert !== 1'b1 || bank[1] !== 32'hDEAD_BEEF)
      $display("FAIL verify alert: got %b %h want 1 deadbeef",
               alert, bank[1]);
    else passes++;
  endtask

  task automatic test_reset_in_write();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 2'd2;
    req_op = OP_WRITE;
    req_wdata = 32'h1111_2222;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_en !== 4'b0)
      $display("FAIL rst_write wr_en: got %b want 0000",
               wr_en);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || alert !== 1'b0 ||
        rsp_valid !== 1'b0 || wr_en !== 4'b0)
      $display("FAIL rst_write idle: got %b%b%b%b want 1000",
               req_ready, alert, rsp_valid, |wr_en);
    else passes++;
    checks++;
    if (bank[2] !== 32'h0000_00FF)
      $display("FAIL rst_write bank: got %h want 000000ff",
               bank[2]);
    else passes++;
  endtask

  task automatic test_out_of_range();
    int lat;
    logic en_any;
    exp_t e;
    lat = -1;
    en_any = 1'b0;
    sb.push_back('{32'h0, 1'b1});
    @(negedge clk);
    v3 = 1'b1;
    a3 = 2'd3;
    op3 = OP_WRITE;
    wd3 = 32'hCAFE_F00D;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) v3 = 1'b0;
      if (en3 !== 3'b0) en_any = 1'b1;
      if (rv3 === 1'b1) begin
        lat = c;
        break;
      end
    end
    e = sb.pop_front();
    checks++;
    if (lat != 2 || en_any !== 1'b0)
      $display("FAIL oor timing: got c%0d en%b want c2 en0",
               lat, en_any);
    else passes++;
    checks++;
    if (rd3 !== e.rdata || re3 !== e.err)
      $display("FAIL oor rsp: got %h/%b want %h/%b",
               rd3, re3, e.rdata, e.err);
    else passes++;
    rr3 = 1'b1;
    @(negedge clk);
    rr3 = 1'b0;
    checks++;
    if (rdy3 !== 1'b1 || rv3 !== 1'b0)
      $display("FAIL oor idle: got rdy%b v%b want rdy1 v0",
               rdy3, rv3);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_set();
    test_clear_stall();
    test_rd_error();
    test_verify_mismatch();
    test_reset_in_write();
    test_out_of_range();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
